core_savestate_ctrl: RTL and testbench

Savestate sequencer between the bridge command handler and the emulated core. It consumes the `savestate_start` and `savestate_load` request levels and answers with the ack/busy/ok/err status that the handler reports to the host. For each request it pauses the core, then copies WORDS 32-bit state words between the core's state port and the savestate buffer RAM that the bridge reads and writes. When the copy is finished it releases the core.

---
 rtl/core_savestate_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_core_savestate_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_savestate_ctrl.sv
// Savestate sequencer: pauses the emulated core, then copies WORDS state words between the core
// state port and the savestate buffer RAM (save: core->buffer, load: buffer->core).
module core_savestate_ctrl #(
  parameter int unsigned WORDS   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              savestate_start,
  output logic              savestate_start_ack,
  output logic              savestate_start_busy,
  output logic              savestate_start_ok,
  output logic              savestate_start_err,
  input  logic              savestate_load,
  output logic              savestate_load_ack,
  output logic              savestate_load_busy,
  output logic              savestate_load_ok,
  output logic              savestate_load_err,
  output logic              core_pause_req,
  input  logic              core_pause_ack,
  output logic [ADDR_W-1:0] state_addr,
  output logic              state_rd,
  input  logic [31:0]       state_rd_data,
  output logic              state_wr,
  output logic [31:0]       state_wr_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_wr,
  output logic [31:0]       buf_wr_data,
  input  logic [31:0]       buf_rd_data
);

  typedef enum logic [2:0] {StIdle, StPause, StSave, StLoad, StRelease} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic              op_load_q, op_load_d;
  logic              start_armed_q, start_armed_d;
  logic              load_armed_q, load_armed_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              start_ack_q, start_ack_d;
  logic              start_busy_q, start_busy_d;
  logic              start_ok_q, start_ok_d;
  logic              start_err_q, start_err_d;
  logic              load_ack_q, load_ack_d;
  logic              load_busy_q, load_busy_d;
  logic              load_ok_q, load_ok_d;
  logic              load_err_q, load_err_d;
  logic              start_req, load_req;

  assign start_req = savestate_start & start_armed_q;
  assign load_req  = savestate_load & load_armed_q;

  always_comb begin
    state_d       = state_q;
    op_load_d     = op_load_q;
    start_armed_d = start_armed_q | ~savestate_start;
    load_armed_d  = load_armed_q | ~savestate_load;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    rd_done_d     = rd_done_q;
    wr_pend_d     = 1'b0;
    wr_idx_d      = wr_idx_q;
    start_ack_d   = 1'b0;
    start_busy_d  = start_busy_q;
    start_ok_d    = start_ok_q;
    start_err_d   = start_err_q;
    load_ack_d    = 1'b0;
    load_busy_d   = load_busy_q;
    load_ok_d     = load_ok_q;
    load_err_d    = load_err_q;

    unique case (state_q)
      StIdle: begin
        // Start has priority; a losing load keeps its level high and is taken later.
        if (start_req) begin
          start_ack_d   = 1'b1;
          start_armed_d = 1'b0;
          start_ok_d    = 1'b0;
          start_err_d   = 1'b0;
          start_busy_d  = 1'b1;
          op_load_d     = 1'b0;
          cnt_d         = 16'(TIMEOUT);
          state_d       = StPause;
        end else if (load_req) begin
          load_ack_d   = 1'b1;
          load_armed_d = 1'b0;
          load_ok_d    = 1'b0;
          load_err_d   = 1'b0;
          load_busy_d  = 1'b1;
          op_load_d    = 1'b1;
          cnt_d        = 16'(TIMEOUT);
          state_d      = StPause;
        end
      end
      StPause: begin
        if (core_pause_ack) begin
          state_d   = op_load_q ? StLoad : StSave;
          idx_d     = '0;
          rd_done_d = 1'b0;
        end else if (cnt_q == 16'd0) begin
          if (op_load_q) begin
            load_err_d  = 1'b1;
            load_busy_d = 1'b0;
          end else begin
            start_err_d  = 1'b1;
            start_busy_d = 1'b0;
          end
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StSave, StLoad: begin
        // Read side issues one word per cycle; write side trails it by exactly one cycle.
        if (!rd_done_q) begin
          wr_pend_d = 1'b1;
          wr_idx_d  = idx_q;
          if (idx_q == LastIdx) rd_done_d = 1'b1;
          else                  idx_d     = idx_q + 1'b1;
        end
        if (wr_pend_q && (wr_idx_q == LastIdx)) begin
          if (op_load_q) begin
            load_ok_d   = 1'b1;
            load_busy_d = 1'b0;
          end else begin
            start_ok_d   = 1'b1;
            start_busy_d = 1'b0;
          end
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!core_pause_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      op_load_q     <= 1'b0;
      start_armed_q <= 1'b1;
      load_armed_q  <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      rd_done_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_idx_q      <= '0;
      start_ack_q   <= 1'b0;
      start_busy_q  <= 1'b0;
      start_ok_q    <= 1'b0;
      start_err_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      load_busy_q   <= 1'b0;
      load_ok_q     <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_load_q     <= op_load_d;
      start_armed_q <= start_armed_d;
      load_armed_q  <= load_armed_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      rd_done_q     <= rd_done_d;
      wr_pend_q     <= wr_pend_d;
      wr_idx_q      <= wr_idx_d;
      start_ack_q   <= start_ack_d;
      start_busy_q  <= start_busy_d;
      start_ok_q    <= start_ok_d;
      start_err_q   <= start_err_d;
      load_ack_q    <= load_ack_d;
      load_busy_q   <= load_busy_d;
      load_ok_q     <= load_ok_d;
      load_err_q    <= load_err_d;
    end
  end

  assign savestate_start_ack  = start_ack_q;
  assign savestate_start_busy = start_busy_q;
  assign savestate_start_ok   = start_ok_q;
  assign savestate_start_err  = start_err_q;
  assign savestate_load_ack   = load_ack_q;
  assign savestate_load_busy  = load_busy_q;
  assign savestate_load_ok    = load_ok_q;
  assign savestate_load_err   = load_err_q;

  assign core_pause_req = (state_q == StPause) || (state_q == StSave) || (state_q == StLoad);

  always_comb begin
    state_addr    = '0;
    state_rd      = 1'b0;
    state_wr      = 1'b0;
    state_wr_data = '0;
    buf_addr      = '0;
    buf_wr        = 1'b0;
    buf_wr_data   = '0;
    unique case (state_q)
      StSave: begin
        if (!rd_done_q) begin
          state_addr = idx_q;
          state_rd   = 1'b1;
        end
        if (wr_pend_q) begin
          buf_addr    = wr_idx_q;
          buf_wr      = 1'b1;
          buf_wr_data = state_rd_data;
        end
      end
      StLoad: begin
        if (!rd_done_q) buf_addr = idx_q;
        if (wr_pend_q) begin
          state_addr    = wr_idx_q;
          state_wr      = 1'b1;
          state_wr_data = buf_rd_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_savestate_ctrl.sv
// Scoreboard bench for core_savestate_ctrl: directed scenarios plus randomized save/load traffic
// against a transaction-level model of core and buffer contents.
module tb_core_savestate_ctrl;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned TIMEOUT = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              savestate_start = 1'b0, savestate_load = 1'b0;
  logic              savestate_start_ack, savestate_start_busy, savestate_start_ok;
  logic              savestate_start_err;
  logic              savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err;
  logic              core_pause_req;
  logic              core_pause_ack = 1'b0;
  logic [ADDR_W-1:0] state_addr, buf_addr;
  logic              state_rd, state_wr, buf_wr;
  logic [31:0]       state_rd_data = '0, buf_rd_data = '0, state_wr_data, buf_wr_data;

  core_savestate_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .savestate_start      (savestate_start),
    .savestate_start_ack  (savestate_start_ack),
    .savestate_start_busy (savestate_start_busy),
    .savestate_start_ok   (savestate_start_ok),
    .savestate_start_err  (savestate_start_err),
    .savestate_load       (savestate_load),
    .savestate_load_ack   (savestate_load_ack),
    .savestate_load_busy  (savestate_load_busy),
    .savestate_load_ok    (savestate_load_ok),
    .savestate_load_err   (savestate_load_err),
    .core_pause_req       (core_pause_req),
    .core_pause_ack       (core_pause_ack),
    .state_addr           (state_addr),
    .state_rd             (state_rd),
    .state_rd_data        (state_rd_data),
    .state_wr             (state_wr),
    .state_wr_data        (state_wr_data),
    .buf_addr             (buf_addr),
    .buf_wr               (buf_wr),
    .buf_wr_data          (buf_wr_data),
    .buf_rd_data          (buf_rd_data)
  );

  // Environment: core state RAM, buffer RAM, and a core that freezes after pause_delay cycles.
  logic [31:0]       core_mem [WORDS];
  logic [31:0]       buf_mem  [WORDS];
  logic              host_core_we = 1'b0, host_buf_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [31:0]       host_data = '0;
  int unsigned       pause_delay = 0;
  bit                pause_never = 1'b0;
  int unsigned       pause_cnt = 0;

  always @(posedge clk) begin
    if (state_rd) state_rd_data <= core_mem[state_addr];
    if (state_wr) core_mem[state_addr] <= state_wr_data;
    buf_rd_data <= buf_mem[buf_addr];
    if (buf_wr) buf_mem[buf_addr] <= buf_wr_data;
    if (host_core_we) core_mem[host_addr] <= host_data;
    if (host_buf_we) buf_mem[host_addr] <= host_data;
    if (core_pause_req) begin
      pause_cnt      <= pause_cnt + 1;
      core_pause_ack <= !pause_never && (pause_cnt >= pause_delay);
    end else begin
      pause_cnt      <= 0;
      core_pause_ack <= 1'b0;
    end
  end

  // Scoreboard
  typedef enum int {EvStartAck, EvLoadAck, EvBufWr, EvStateWr,
                    EvStartOk, EvStartErr, EvLoadOk, EvLoadErr} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned addr;
    logic [31:0] data;
  } ev_t;

  ev_t sb_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  logic [31:0] m_core [WORDS];
  logic [31:0] m_buf  [WORDS];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(ev_kind_e k, int unsigned a, logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endfunction

  function automatic void got_event(ev_kind_e k, int unsigned a, logic [31:0] d);
    ev_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s addr=%0d data=0x%h, expected no event",
               k.name(), a, d);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.addr != a || e.data !== d) begin
        n_fail++;
        $display("FAIL scoreboard: got %s addr=%0d data=0x%h, expected %s addr=%0d data=0x%h",
                 k.name(), a, d, e.kind.name(), e.addr, e.data);
      end
    end
  endfunction

  // Whole-transaction model: a save copies the core image into the buffer, a load the reverse.
  function automatic void push_op(bit is_load, bit timeout);
    push_ev(is_load ? EvLoadAck : EvStartAck, 0, '0);
    if (timeout) begin
      push_ev(is_load ? EvLoadErr : EvStartErr, 0, '0);
    end else begin
      for (int k = 0; k < int'(WORDS); k++) begin
        if (is_load) begin
          push_ev(EvStateWr, k, m_buf[k]);
          m_core[k] = m_buf[k];
        end else begin
          push_ev(EvBufWr, k, m_core[k]);
          m_buf[k] = m_core[k];
        end
      end
      push_ev(is_load ? EvLoadOk : EvStartOk, 0, '0);
    end
  endfunction

  logic prev_sok = 1'b0, prev_serr = 1'b0, prev_lok = 1'b0, prev_lerr = 1'b0;

  always @(negedge clk) begin
    if (savestate_start_ack) got_event(EvStartAck, 0, '0);
    if (savestate_load_ack) got_event(EvLoadAck, 0, '0);
    if (buf_wr) got_event(EvBufWr, 32'(buf_addr), buf_wr_data);
    if (state_wr) got_event(EvStateWr, 32'(state_addr), state_wr_data);
    if (savestate_start_ok && !prev_sok) got_event(EvStartOk, 0, '0);
    if (savestate_start_err && !prev_serr) got_event(EvStartErr, 0, '0);
    if (savestate_load_ok && !prev_lok) got_event(EvLoadOk, 0, '0);
    if (savestate_load_err && !prev_lerr) got_event(EvLoadErr, 0, '0);
    prev_sok  <= savestate_start_ok;
    prev_serr <= savestate_start_err;
    prev_lok  <= savestate_load_ok;
    prev_lerr <= savestate_load_err;
  end

  // Stimulus helpers
  task automatic host_write(bit to_core, int unsigned addr, logic [31:0] data);
    @(negedge clk);
    host_core_we = to_core;
    host_buf_we  = !to_core;
    host_addr    = ADDR_W'(addr);
    host_data    = data;
    if (to_core) m_core[addr] = data;
    else         m_buf[addr]  = data;
    @(negedge clk);
    host_core_we = 1'b0;
    host_buf_we  = 1'b0;
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_ctrl"}, 64'({savestate_start_ack, savestate_start_busy, savestate_start_ok,
                                savestate_start_err, savestate_load_ack, savestate_load_busy,
                                savestate_load_ok, savestate_load_err, core_pause_req,
                                state_addr, state_rd, state_wr, buf_addr, buf_wr}), 64'd0);
    check({name, "_data"}, {state_wr_data, buf_wr_data}, 64'd0);
  endtask

  task automatic wait_ack(bit is_load);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (is_load ? savestate_load_ack : savestate_start_ack) begin
        seen = 1'b1;
        check(is_load ? "load_busy_at_ack" : "start_busy_at_ack",
              64'(is_load ? savestate_load_busy : savestate_start_busy), 64'd1);
        check(is_load ? "load_status_cleared" : "start_status_cleared",
              64'(is_load ? {savestate_load_ok, savestate_load_err}
                          : {savestate_start_ok, savestate_start_err}), 64'd0);
      end
    end
    check(is_load ? "load_ack_seen" : "start_ack_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_done(bit is_load, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (is_load ? (savestate_load_ok | savestate_load_err)
                  : (savestate_start_ok | savestate_start_err)) seen = 1'b1;
    end
    check(is_load ? "load_done_seen" : "start_done_seen", 64'(seen), 64'd1);
    if (seen) check(is_load ? "load_busy_after_done" : "start_busy_after_done",
                    64'(is_load ? savestate_load_busy : savestate_start_busy), 64'd0);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!core_pause_req && !core_pause_ack && !savestate_start_busy && !savestate_load_busy)
        seen = 1'b1;
    end
    check("return_idle", 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_op(bit is_load, int unsigned delay, bit never);
    int cyc;
    logic [2:0] other;
    pause_delay = delay;
    pause_never = never;
    other = is_load ? {savestate_start_busy, savestate_start_ok, savestate_start_err}
                    : {savestate_load_busy, savestate_load_ok, savestate_load_err};
    push_op(is_load, never);
    @(negedge clk);
    if (is_load) savestate_load = 1'b1;
    else         savestate_start = 1'b1;
    wait_ack(is_load);
    savestate_start = 1'b0;
    savestate_load  = 1'b0;
    wait_done(is_load, cyc);
    if (never) begin
      check("timeout_latency", 64'(cyc), 64'(TIMEOUT + 1));
      check("timeout_no_ok", 64'(is_load ? savestate_load_ok : savestate_start_ok), 64'd0);
    end
    check(is_load ? "start_status_untouched" : "load_status_untouched",
          64'(is_load ? {savestate_start_busy, savestate_start_ok, savestate_start_err}
                      : {savestate_load_busy, savestate_load_ok, savestate_load_err}),
          64'(other));
    wait_idle();
    pause_never = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_ack;
    logic [31:0] saved_buf3;
    bit seen;

    for (int k = 0; k < int'(WORDS); k++) begin
      core_mem[k] = '0;
      buf_mem[k]  = '0;
      m_core[k]   = '0;
      m_buf[k]    = '0;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    // Directed save with image 0xA0..0xA3, core freezing two cycles after the request.
    for (int k = 0; k < int'(WORDS); k++) host_write(1'b1, k, 32'hA0 + 32'(k));
    run_op(1'b0, 2, 1'b0);

    // Directed load from buffer 0x11..0x14.
    for (int k = 0; k < int'(WORDS); k++) host_write(1'b0, k, 32'h11 + 32'(k));
    run_op(1'b1, 1, 1'b0);

    // Core never freezes: both request types time out.
    run_op(1'b0, 0, 1'b1);
    run_op(1'b1, 0, 1'b1);

    // Both requests in the same cycle: save first, load after release.
    pause_delay = 2;
    push_op(1'b0, 1'b0);
    push_op(1'b1, 1'b0);
    @(negedge clk);
    savestate_start = 1'b1;
    savestate_load  = 1'b1;
    wait_ack(1'b0);
    savestate_start = 1'b0;
    wait_ack(1'b1);
    savestate_load = 1'b0;
    wait_done(1'b1, cyc);
    wait_idle();

    // Held request level must not retrigger until it has been low for a cycle.
    pause_delay = 1;
    push_op(1'b0, 1'b0);
    @(negedge clk);
    savestate_start = 1'b1;
    wait_ack(1'b0);
    wait_done(1'b0, cyc);
    wait_idle();
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (savestate_start_ack) n_ack++;
    end
    check("held_level_no_reack", 64'(n_ack), 64'd0);
    savestate_start = 1'b0;
    @(negedge clk);
    push_op(1'b0, 1'b0);
    savestate_start = 1'b1;
    wait_ack(1'b0);
    savestate_start = 1'b0;
    wait_done(1'b0, cyc);
    wait_idle();

    // Reset while the third word is being written into the buffer.
    for (int k = 0; k < int'(WORDS); k++) host_write(1'b1, k, $urandom());
    saved_buf3 = m_buf[WORDS-1];
    pause_delay = 1;
    push_op(1'b0, 1'b0);
    @(negedge clk);
    savestate_start = 1'b1;
    wait_ack(1'b0);
    savestate_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (buf_wr && buf_addr == 2'd2) seen = 1'b1;
    end
    check("reset_word2_reached", 64'(seen), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_save_reset");
    sb_q.delete();
    m_buf[WORDS-1] = saved_buf3;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 0, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1)
        host_write($urandom_range(0, 1) == 1, $urandom_range(0, WORDS - 1), $urandom());
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 4), $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    for (int k = 0; k < int'(WORDS); k++) begin
      check("final_core_image", 64'(core_mem[k]), 64'(m_core[k]));
      check("final_buf_image", 64'(buf_mem[k]), 64'(m_buf[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
